load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 23 ++
 rtl/lsu_byte_lane.sv | 32 +++
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the byte-serial load/store unit.
//   lsuState_t     : FSM state encoding (IDLE, B0..B2 byte beats, DONE)
//   BYTES_PER_WORD : bytes moved per word access
//   LANE_W         : width of a byte-lane index
//   isBurst()      : true in the three byte-beat states
package load_store_unit_pkg;

  localparam int BYTES_PER_WORD = 3;
  localparam int LANE_W         = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    DONE = 3'd4
  } lsuState_t;

  function automatic logic isBurst(input lsuState_t s);
    return (s == B0) || (s == B1) || (s == B2);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper for the load/store unit. Lane 0 is the most significant
// byte of the word (big-endian), lane BYTES_PER_WORD-1 the least significant.
// Ports:
//   lane       in  lane index
//   word       in  word to select from / insert into
//   byteIn     in  byte to insert at the lane
//   selByte    out byte of word at the lane (0 for an out-of-range lane)
//   insertWord out word with the lane replaced by byteIn
module lsu_byte_lane
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic [LANE_W-1:0] lane,
  input  logic [DATA_W-1:0] word,
  input  logic [7:0]        byteIn,
  output logic [7:0]        selByte,
  output logic [DATA_W-1:0] insertWord
);

  always_comb begin
    selByte    = 8'h00;
    insertWord = word;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane == LANE_W'(i)) begin
        selByte = word[(BYTES_PER_WORD-1-i)*8 +: 8];
        insertWord[(BYTES_PER_WORD-1-i)*8 +: 8] = byteIn;
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Word load/store unit in front of a byte-wide data memory. Each accepted
// request moves one 3-byte word as three single-byte beats, MSB byte first.
// Optional build macro: LSU_BOUNDS_CHECK_EN -- rejects accesses whose last
// byte would fall beyond MEM_BYTES (err=1, no memory strobes).
// Ports:
//   clock, reset        clock, synchronous active-high reset
//   req, we, addr, wdata CPU request (sampled only in IDLE)
//   busy, done, rdata, err  CPU status / load result
//   mem_addr, mem_wdata, mem_we, mem_re, mem_rdata  byte memory port
//
// state | meaning
// IDLE  | waiting for req; request fields latched on acceptance
// B0    | byte beat at addr+0, bits [23:16]
// B1    | byte beat at addr+1, bits [15:8]
// B2    | byte beat at addr+2, bits [7:0]
// DONE  | one-cycle completion pulse
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 24,
  parameter int MEM_BYTES = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  lsuState_t state, nextState;

  logic [ADDR_W-1:0] addrQ;
  logic              weQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] rdataQ;

  logic              inBurst;
  logic              accept;
  logic              outOfRange;
  logic [2:0]        stateBits;
  logic [LANE_W-1:0] laneIdx;
  logic [DATA_W-1:0] laneWord;
  logic [7:0]        laneByte;
  logic [DATA_W-1:0] insertWord;

  assign inBurst   = isBurst(state);
  assign accept    = (state == IDLE) && req;
  assign stateBits = state;
  // B0/B1/B2 are encoded 1/2/3, so the lane is simply state-1.
  assign laneIdx   = LANE_W'(stateBits - 3'd1);

  // Highest legal word address leaves room for all three bytes.
  assign outOfRange = addr > ADDR_W'(MEM_BYTES - BYTES_PER_WORD);

  // One lane helper serves both directions: stores select from the latched
  // write word, loads insert the memory byte into the running read word.
  assign laneWord = weQ ? wdataQ : rdataQ;

  lsu_byte_lane #(
    .DATA_W(DATA_W)
  ) uByteLane (
    .lane      (laneIdx),
    .word      (laneWord),
    .byteIn    (mem_rdata),
    .selByte   (laneByte),
    .insertWord(insertWord)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (req) begin
`ifdef LSU_BOUNDS_CHECK_EN
          nextState = outOfRange ? DONE : B0;
`else
          nextState = B0;
`endif
        end
      end
      B0:      nextState = B1;
      B1:      nextState = B2;
      B2:      nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request latch and load assembly
  always_ff @(posedge clock) begin
    if (reset) begin
      addrQ  <= '0;
      weQ    <= 1'b0;
      wdataQ <= '0;
      rdataQ <= '0;
    end else begin
      if (accept) begin
        addrQ  <= addr;
        weQ    <= we;
        wdataQ <= wdata;
      end
      if (inBurst && !weQ) begin
        rdataQ <= insertWord;
      end
    end
  end

`ifdef LSU_BOUNDS_CHECK_EN
  logic errQ;

  // err is re-evaluated on every acceptance and held until the next one.
  always_ff @(posedge clock) begin
    if (reset) begin
      errQ <= 1'b0;
    end else if (accept) begin
      errQ <= outOfRange;
    end
  end

  assign err = errQ;
`else
  // The range compare is only consumed when bounds checking is built in.
  logic unusedOutOfRange;
  assign unusedOutOfRange = outOfRange;
  assign err = 1'b0;
`endif

  assign rdata = rdataQ;

  // Output logic. Strobes are gated by reset so an aborted access cannot
  // write one more byte on the very edge that resets the FSM.
  always_comb begin
    busy      = inBurst;
    done      = (state == DONE);
    mem_we    = inBurst && weQ && !reset;
    mem_re    = inBurst && !weQ && !reset;
    mem_addr  = inBurst ? (addrQ + ADDR_W'(laneIdx)) : addrQ;
    mem_wdata = mem_we ? laneByte : 8'h00;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [23:0] addr  = 24'h0;
  logic [23:0] wdata = 24'h0;
  logic        busy, done, err, memWe, memRe;
  logic [23:0] rdata, memAddr;
  logic [7:0]  memWdata, memRdata;

  logic [7:0]  memArr [0:255] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (memWe) memArr[memAddr[7:0]] <= memWdata;
  end
  assign memRdata = memArr[memAddr[7:0]];

  load_store_unit dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .mem_addr (memAddr),
    .mem_wdata(memWdata),
    .mem_we   (memWe),
    .mem_re   (memRe),
    .mem_rdata(memRdata)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, err, memWe, memRe} !== 5'b0) begin
      $display("FAIL reset_flags got %b want 00000", {busy, done, err, memWe, memRe});
      errors++;
    end
    checks++;
    if ({rdata, memAddr, memWdata} !== 56'h0) begin
      $display("FAIL reset_data got rdata=%h addr=%h wdata=%h want 0", rdata, memAddr, memWdata);
      errors++;
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_idle busy got %b want 0", busy);
      errors++;
    end
  endtask

  task automatic test_store;
    logic [7:0] expB [3];
    expB[0] = 8'hA1; expB[1] = 8'hB2; expB[2] = 8'hC3;
    req = 1'b1; we = 1'b1; addr = 24'h000010; wdata = 24'hA1B2C3;
    tick();
    req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy, memWe, memRe, memAddr, memWdata} !== {3'b110, 24'h10 + 24'(k), expB[k]}) begin
        $display("FAIL store_beat%0d got busy=%b we=%b re=%b addr=%h data=%h want 1 1 0 %h %h",
                 k, busy, memWe, memRe, memAddr, memWdata, 24'h10 + 24'(k), expB[k]);
        errors++;
      end
      tick();
    end
    checks++;
    if ({done, busy, memWe, memRe, memAddr, memWdata} !== {4'b1000, 24'h10, 8'h00}) begin
      $display("FAIL store_done got done=%b busy=%b we=%b re=%b addr=%h data=%h want 1 0 0 0 000010 00",
               done, busy, memWe, memRe, memAddr, memWdata);
      errors++;
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      $display("FAIL store_done_pulse got %b want 0", done);
      errors++;
    end
    checks++;
    if ({memArr[8'h10], memArr[8'h11], memArr[8'h12]} !== 24'hA1B2C3) begin
      $display("FAIL store_mem got %h%h%h want a1b2c3", memArr[8'h10], memArr[8'h11], memArr[8'h12]);
      errors++;
    end
    checks++;
    if (rdata !== 24'h0) begin
      $display("FAIL store_rdata_kept got %h want 000000", rdata);
      errors++;
    end
  endtask

  task automatic test_load;
    int reCount = 0;
    int doneCycle = -1;
    logic weSeen = 1'b0;
    logic [23:0] rdataAtDone = 24'hx;
    logic errAtDone = 1'bx;
    req = 1'b1; we = 1'b0; addr = 24'h000010; wdata = 24'h0;
    tick();
    req = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (memRe) reCount++;
      if (memWe) weSeen = 1'b1;
      if (done) begin
        doneCycle = c;
        rdataAtDone = rdata;
        errAtDone = err;
      end
      tick();
    end
    checks++;
    if (reCount != 3) begin
      $display("FAIL load_re_count got %0d want 3", reCount);
      errors++;
    end
    checks++;
    if (weSeen !== 1'b0) begin
      $display("FAIL load_no_we got %b want 0", weSeen);
      errors++;
    end
    checks++;
    if (doneCycle != 4) begin
      $display("FAIL load_latency got %0d want 4", doneCycle);
      errors++;
    end
    checks++;
    if (rdataAtDone !== 24'hA1B2C3 || errAtDone !== 1'b0) begin
      $display("FAIL load_rdata got %h err=%b want a1b2c3 err=0", rdataAtDone, errAtDone);
      errors++;
    end
  endtask

  task automatic test_back_to_back;
    int doneAt [3] = '{-1, -1, -1};
    int nDone = 0;
    req = 1'b1; we = 1'b0; addr = 24'h000010;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 12) req = 1'b0;
      if (done) begin
        if (nDone < 3) doneAt[nDone] = c;
        nDone++;
      end
    end
    checks++;
    if (nDone != 3) begin
      $display("FAIL b2b_count got %0d want 3", nDone);
      errors++;
    end
    checks++;
    if (doneAt[0] != 4 || doneAt[1] != 9 || doneAt[2] != 14) begin
      $display("FAIL b2b_done_cycles got %0d %0d %0d want 4 9 14", doneAt[0], doneAt[1], doneAt[2]);
      errors++;
    end
    checks++;
    if (rdata !== 24'hA1B2C3) begin
      $display("FAIL b2b_rdata got %h want a1b2c3", rdata);
      errors++;
    end
  endtask

  task automatic test_wrap_store;
    logic [23:0] expA [3];
    logic [7:0]  expB [3];
    expA[0] = 24'hFFFFFF; expA[1] = 24'h000000; expA[2] = 24'h000001;
    expB[0] = 8'h44; expB[1] = 8'h55; expB[2] = 8'h66;
    req = 1'b1; we = 1'b1; addr = 24'hFFFFFF; wdata = 24'h445566;
    tick();
    req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({memWe, memAddr, memWdata} !== {1'b1, expA[k], expB[k]}) begin
        $display("FAIL wrap_beat%0d got we=%b addr=%h data=%h want 1 %h %h",
                 k, memWe, memAddr, memWdata, expA[k], expB[k]);
        errors++;
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || rdata !== 24'hA1B2C3) begin
      $display("FAIL wrap_done got done=%b rdata=%h want 1 a1b2c3", done, rdata);
      errors++;
    end
    tick();
  endtask

  task automatic test_boundary;
    int reCount = 0;
    int strobes = 0;
    int doneCycle = -1;
    logic [23:0] rdataAtDone = 24'hx;
    logic errAtDone = 1'bx;
`ifdef LSU_BOUNDS_CHECK_EN
    req = 1'b1; we = 1'b0; addr = 24'h00007E;
    tick();
    req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (memWe || memRe) strobes++;
      if (done) begin
        doneCycle = c;
        rdataAtDone = rdata;
        errAtDone = err;
      end
      tick();
    end
    checks++;
    if (strobes != 0) begin
      $display("FAIL bounds_strobes got %0d want 0", strobes);
      errors++;
    end
    checks++;
    if (doneCycle != 1) begin
      $display("FAIL bounds_latency got %0d want 1", doneCycle);
      errors++;
    end
    checks++;
    if (errAtDone !== 1'b1 || rdataAtDone !== 24'hA1B2C3) begin
      $display("FAIL bounds_err got err=%b rdata=%h want 1 a1b2c3", errAtDone, rdataAtDone);
      errors++;
    end
`else
    req = 1'b1; we = 1'b1; addr = 24'h00007E; wdata = 24'h0C0D0E;
    tick();
    req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    req = 1'b1; we = 1'b0; addr = 24'h00007E;
    tick();
    req = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (memRe) begin
        checks++;
        if (memAddr !== 24'h7E + 24'(reCount)) begin
          $display("FAIL edge_addr%0d got %h want %h", reCount, memAddr, 24'h7E + 24'(reCount));
          errors++;
        end
        reCount++;
      end
      if (done) begin
        doneCycle = c;
        rdataAtDone = rdata;
        errAtDone = err;
      end
      tick();
    end
    checks++;
    if (reCount != 3 || doneCycle != 4) begin
      $display("FAIL edge_access got re=%0d done_at=%0d want 3 4", reCount, doneCycle);
      errors++;
    end
    checks++;
    if (errAtDone !== 1'b0 || rdataAtDone !== 24'h0C0D0E) begin
      $display("FAIL edge_rdata got err=%b rdata=%h want 0 0c0d0e", errAtDone, rdataAtDone);
      errors++;
    end
`endif
    strobes = strobes;
  endtask

  task automatic test_reset_priority;
    reset = 1'b1; req = 1'b1; we = 1'b0; addr = 24'h000010;
    tick();
    reset = 1'b0; req = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL prio_idle got busy=%b done=%b want 0 0", busy, done);
      errors++;
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL prio_stay_idle got busy=%b want 0", busy);
      errors++;
    end
  endtask

  task automatic test_abort;
    logic sawActivity = 1'b0;
    req = 1'b1; we = 1'b1; addr = 24'h000020; wdata = 24'h112233;
    tick();
    req = 1'b0;
    tick();
    checks++;
    if (memWe !== 1'b1 || memAddr !== 24'h21) begin
      $display("FAIL abort_in_b1 got we=%b addr=%h want 1 000021", memWe, memAddr);
      errors++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (memWe !== 1'b0 || memRe !== 1'b0) begin
      $display("FAIL abort_gate got we=%b re=%b want 0 0", memWe, memRe);
      errors++;
    end
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, err, memWe, memRe, memAddr, memWdata, rdata} !== 61'h0) begin
      $display("FAIL abort_outputs got busy=%b done=%b we=%b addr=%h data=%h rdata=%h want 0",
               busy, done, memWe, memAddr, memWdata, rdata);
      errors++;
    end
    for (int c = 0; c < 6; c++) begin
      if (done || memWe || memRe) sawActivity = 1'b1;
      tick();
    end
    checks++;
    if (sawActivity !== 1'b0) begin
      $display("FAIL abort_quiet got activity=%b want 0", sawActivity);
      errors++;
    end
    checks++;
    if ({memArr[8'h20], memArr[8'h21], memArr[8'h22]} !== 24'h110000) begin
      $display("FAIL abort_mem got %h%h%h want 110000", memArr[8'h20], memArr[8'h21], memArr[8'h22]);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_wrap_store();
    test_boundary();
    test_reset_priority();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
